// File: rtl/gpio_input_conditioner.sv
// Synchronises, debounces and edge-detects NUM_CH gpio pins, and keeps sticky per-channel
// event flags that feed one maskable, registered interrupt line.
//
// state  | meaning
// STABLE | synchronised pin matches level_out, counter idle
// CHECK  | synchronised pin differs from level_out, counting stable cycles
module gpio_input_conditioner #(
    parameter int NUM_CH          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    input  logic [NUM_CH-1:0] irq_mask,
    input  logic              clear_strobe,
    input  logic [NUM_CH-1:0] clear_mask,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] pending,
    output logic              irq
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] acc_rise;
    logic [NUM_CH-1:0] acc_fall;
    logic [NUM_CH-1:0] pending_d;

    // Pins go straight into the first flop; nothing combinational ahead of it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (s[i] != level_out[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            accept[i] = 1'b1;
                        end else begin
                            state_d[i] = ST_CHECK;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (s[i] == level_out[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        accept[i]  = 1'b1;
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign acc_rise  = accept & s;
    assign acc_fall  = accept & ~s;
    // A set in the same cycle as a clear must survive.
    assign pending_d = (acc_rise & rise_en) | (acc_fall & fall_en)
                     | (pending & ~({NUM_CH{clear_strobe}} & clear_mask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            pending    <= '0;
            irq        <= 1'b0;
        end else begin
            level_out  <= level_out ^ accept;
            rise_pulse <= acc_rise;
            fall_pulse <= acc_fall;
            pending    <= pending_d;
            irq        <= |(pending & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed and randomised checks of gpio_input_conditioner against a window-based model:
// a level is accepted once the last DEBOUNCE_CYCLES synchronised samples all disagree with it.
module tb_gpio_input_conditioner;

    localparam int NCH = 8;
    localparam int SYN = 2;
    localparam int DB  = 4;
    localparam int HL  = SYN + DB;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] raw_in = '0;
    logic [NCH-1:0] rise_en = '0;
    logic [NCH-1:0] fall_en = '0;
    logic [NCH-1:0] irq_mask = '0;
    logic           clear_strobe = 1'b0;
    logic [NCH-1:0] clear_mask = '0;
    logic [NCH-1:0] level_out;
    logic [NCH-1:0] rise_pulse;
    logic [NCH-1:0] fall_pulse;
    logic [NCH-1:0] pending;
    logic           irq;

    int errors = 0;
    int checks = 0;

    logic [NCH-1:0] hist [HL];
    logic [NCH-1:0] m_level, m_rise, m_fall, m_pend;
    logic           m_irq;

    gpio_input_conditioner #(
        .NUM_CH(NCH), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DB), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in), .rise_en(rise_en), .fall_en(fall_en),
        .irq_mask(irq_mask), .clear_strobe(clear_strobe), .clear_mask(clear_mask),
        .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .pending(pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < HL; k++) hist[k] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
    endtask

    // hist[j] is the pin value sampled j edges ago; the FSM sees it SYN edges later.
    task automatic model_edge();
        logic [NCH-1:0] acc;
        for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = raw_in;
        acc = '1;
        for (int j = SYN; j < SYN + DB; j++) acc &= hist[j] ^ m_level;
        m_rise  = acc & ~m_level;
        m_fall  = acc & m_level;
        m_irq   = |(m_pend & irq_mask);
        m_pend  = (m_rise & rise_en) | (m_fall & fall_en)
                | (m_pend & ~(clear_strobe ? clear_mask : '0));
        m_level = m_level ^ acc;
    endtask

    task automatic compare_all();
        check("level_out", level_out, m_level);
        check("rise_pulse", rise_pulse, m_rise);
        check("fall_pulse", fall_pulse, m_fall);
        check("pending", pending, m_pend);
        check("irq", {7'd0, irq}, {7'd0, m_irq});
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_edge();
            #1;
            compare_all();
        end
    endtask

    initial begin
        model_reset();

        // 1: pins high through reset, accept at edge 6 after release
        raw_in = 8'hFF;
        #2;
        compare_all();
        step(3);
        rst = 1'b1;
        step(5);
        check("t1_level_before", level_out, 8'h00);
        step(1);
        check("t1_level_edge6", level_out, 8'hFF);
        check("t1_rise_edge6", rise_pulse, 8'hFF);
        step(1);
        check("t1_rise_one_cycle", rise_pulse, 8'h00);
        check("t1_pending", pending, 8'h00);

        raw_in = 8'h00;
        step(8);
        check("t1_settle_low", level_out, 8'h00);

        // 2: 3-cycle glitch rejected
        raw_in[0] = 1'b1;
        step(3);
        raw_in[0] = 1'b0;
        step(8);
        check("t2_level0", level_out, 8'h00);
        check("t2_pending", pending, 8'h00);

        // 3: held press with rise event and interrupt
        rise_en = 8'h08; irq_mask = 8'h08;
        raw_in[3] = 1'b1;
        step(6);
        check("t3_rise3", rise_pulse, 8'h08);
        check("t3_pending", pending, 8'h08);
        step(1);
        check("t3_irq", {7'd0, irq}, 8'h01);
        step(3);
        raw_in[3] = 1'b0;
        step(6);
        check("t3_fall3", fall_pulse, 8'h08);
        step(4);
        check("t3_pending_sticky", pending, 8'h08);

        // 4: set wins over same-cycle clear, then clear alone
        raw_in[3] = 1'b1;
        step(5);
        clear_strobe = 1'b1; clear_mask = 8'h08;
        step(1);
        check("t4_rise_accept", rise_pulse, 8'h08);
        check("t4_set_wins", pending, 8'h08);
        step(1);
        check("t4_cleared", pending, 8'h00);
        check("t4_irq_lag", {7'd0, irq}, 8'h01);
        clear_strobe = 1'b0; clear_mask = 8'h00;
        step(1);
        check("t4_irq_low", {7'd0, irq}, 8'h00);

        // 5: simultaneous accepts
        raw_in = 8'h00;
        step(8);
        clear_strobe = 1'b1; clear_mask = 8'hFF;
        step(1);
        clear_strobe = 1'b0; clear_mask = 8'h00;
        rise_en = 8'hFF;
        raw_in = 8'hA5;
        step(6);
        check("t5_rise_all", rise_pulse, 8'hA5);
        check("t5_pending", pending, 8'hA5);

        // 6: reset mid-debounce discards progress
        raw_in = 8'h00;
        step(8);
        clear_strobe = 1'b1; clear_mask = 8'hFF;
        step(1);
        clear_strobe = 1'b0; clear_mask = 8'h00;
        raw_in[2] = 1'b1;
        step(4);
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        raw_in[2] = 1'b0;
        step(2);
        rst = 1'b1;
        step(8);
        check("t6_level2", level_out, 8'h00);
        check("t6_pending", pending, 8'h00);

        // randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NCH; b++)
                if ($urandom_range(5) == 0) raw_in[b] = ~raw_in[b];
            if ((c % 40) == 0) begin
                rise_en  = 8'($urandom);
                fall_en  = 8'($urandom);
                irq_mask = 8'($urandom);
            end
            clear_strobe = ($urandom_range(7) == 0);
            clear_mask   = 8'($urandom);
            if (c == 200) begin
                rst = 1'b0;
                model_reset();
                #1;
                compare_all();
                step(2);
                rst = 1'b1;
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
